// File: rtl/secam_fm_demodulator.sv
// SECAM chroma FM demodulator.
//
// Measures the duration of PERIODS carrier cycles by counting valid input
// samples between upward zero crossings (with hysteresis), then reports the
// deviation of that count from the nominal count of the current line's
// carrier (Db or Dr) as a saturated signed 8-bit value.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   in_valid     qualifies `in` for one cycle
//   in           signed, DC-free bandpassed chroma sample
//   line_start   single-cycle pulse at start of active line
//   line_is_dr   carrier type of the starting line (1 = Dr), used with line_start
//   out_valid    single-cycle strobe, out_dev/out_is_dr valid
//   out_dev      signed deviation = nominal - measured count, saturated
//   out_is_dr    carrier type that out_dev belongs to
//   carrier_lost sticky loss flag, cleared by the next out_valid
module secam_fm_demodulator #(
    parameter int unsigned PERIODS = 4,
    parameter int unsigned NOM_DB  = 40,
    parameter int unsigned NOM_DR  = 38,
    parameter int unsigned HYST    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic signed [7:0] in,
    input  logic              line_start,
    input  logic              line_is_dr,
    output logic              out_valid,
    output logic [7:0]        out_dev,
    output logic              out_is_dr,
    output logic              carrier_lost
);

    typedef enum logic [1:0] {
        IDLE,
        ARM_NEG,
        MEAS_POS,
        MEAS_NEG
    } state_t;

    localparam int              HYST_I    = int'(HYST);
    localparam logic signed [7:0] HYST_POS = 8'(HYST_I);
    localparam logic signed [7:0] HYST_NEG = 8'(-HYST_I);
    localparam logic [3:0]      PERIODS_L = 4'(PERIODS);
    localparam logic [9:0]      NOM_DB_L  = 10'(NOM_DB);
    localparam logic [9:0]      NOM_DR_L  = 10'(NOM_DR);
    localparam logic [9:0]      TIMEOUT_L = 10'(TIMEOUT);

    state_t      state_q, state_d;
    logic [9:0]  sample_cnt_q, sample_cnt_d;
    logic [3:0]  period_cnt_q, period_cnt_d;
    logic        line_dr_q, line_dr_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_dev_q, out_dev_d;
    logic        out_is_dr_q, out_is_dr_d;
    logic        carrier_lost_q, carrier_lost_d;

    logic              is_pos, is_neg;
    logic [9:0]        sample_inc;
    logic [3:0]        period_inc;
    logic [9:0]        nom;
    logic signed [10:0] dev;
    logic [7:0]        dev_sat;
    logic              open_win, close_win;

    assign is_pos     = (in >= HYST_POS);
    assign is_neg     = (in <= HYST_NEG);
    assign sample_inc = sample_cnt_q + 10'd1;
    assign period_inc = period_cnt_q + 4'd1;
    assign nom        = line_dr_q ? NOM_DR_L : NOM_DB_L;

    // Measured count includes the closing sample, hence sample_inc.
    always_comb begin
        dev = $signed({1'b0, nom}) - $signed({1'b0, sample_inc});
        if (dev > 11'sd127) begin
            dev_sat = 8'h7f;
        end else if (dev < -11'sd128) begin
            dev_sat = 8'h80;
        end else begin
            dev_sat = dev[7:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
        period_cnt_d   = period_cnt_q;
        line_dr_d      = line_dr_q;
        out_valid_d    = 1'b0;
        out_dev_d      = out_dev_q;
        out_is_dr_d    = out_is_dr_q;
        carrier_lost_d = carrier_lost_q;
        open_win       = 1'b0;
        close_win      = 1'b0;

        if (line_start) begin
            // Coincident sample is dropped; partial window discarded.
            line_dr_d    = line_is_dr;
            sample_cnt_d = '0;
            period_cnt_d = '0;
            state_d      = IDLE;
        end else if (in_valid) begin
            sample_cnt_d = sample_inc;
            unique case (state_q)
                IDLE: begin
                    if (is_neg) state_d = ARM_NEG;
                end
                ARM_NEG: begin
                    if (is_pos) begin
                        open_win = 1'b1;
                        state_d  = MEAS_POS;
                    end
                end
                MEAS_POS: begin
                    if (is_neg) state_d = MEAS_NEG;
                end
                MEAS_NEG: begin
                    if (is_pos) begin
                        state_d = MEAS_POS;
                        if (period_inc == PERIODS_L) begin
                            close_win = 1'b1;
                        end else begin
                            period_cnt_d = period_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Close wins over timeout; the closing crossing opens the next window.
            if (open_win) begin
                sample_cnt_d = '0;
                period_cnt_d = '0;
            end else if (close_win) begin
                sample_cnt_d   = '0;
                period_cnt_d   = '0;
                out_valid_d    = 1'b1;
                out_dev_d      = dev_sat;
                out_is_dr_d    = line_dr_q;
                carrier_lost_d = 1'b0;
            end else if (sample_inc == TIMEOUT_L) begin
                carrier_lost_d = 1'b1;
                sample_cnt_d   = '0;
                period_cnt_d   = '0;
                state_d        = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            sample_cnt_q   <= '0;
            period_cnt_q   <= '0;
            line_dr_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_dev_q      <= '0;
            out_is_dr_q    <= 1'b0;
            carrier_lost_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_cnt_q   <= sample_cnt_d;
            period_cnt_q   <= period_cnt_d;
            line_dr_q      <= line_dr_d;
            out_valid_q    <= out_valid_d;
            out_dev_q      <= out_dev_d;
            out_is_dr_q    <= out_is_dr_d;
            carrier_lost_q <= carrier_lost_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_dev      = out_dev_q;
    assign out_is_dr    = out_is_dr_q;
    assign carrier_lost = carrier_lost_q;

endmodule

// File: tb/tb_secam_fm_demodulator.sv
// Testbench for secam_fm_demodulator: randomized square-wave stimulus,
// reference model in terms of crossings and sample indices, scoreboard
// queue of expected results drained by an independent monitor.
module tb_secam_fm_demodulator;

    localparam int PERIODS = 4;
    localparam int NOM_DB  = 40;
    localparam int NOM_DR  = 38;
    localparam int HYST    = 8;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic signed [7:0] in;
    logic              line_start;
    logic              line_is_dr;
    logic              out_valid;
    logic [7:0]        out_dev;
    logic              out_is_dr;
    logic              carrier_lost;

    secam_fm_demodulator #(
        .PERIODS(PERIODS),
        .NOM_DB (NOM_DB),
        .NOM_DR (NOM_DR),
        .HYST   (HYST),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in          (in),
        .line_start  (line_start),
        .line_is_dr  (line_is_dr),
        .out_valid   (out_valid),
        .out_dev     (out_dev),
        .out_is_dr   (out_is_dr),
        .carrier_lost(carrier_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int dev;
        int is_dr;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a window is the span between an opening upward
    // crossing and the PERIODS-th following upward crossing. An upward
    // crossing is a decisive positive sample whose previous decisive sample
    // (since the last restart) was negative.
    int m_idx;       // valid samples since last restart / window start
    int m_cross;     // crossings counted in the current window
    bit m_in_win;
    bit m_last_neg;
    bit m_dr;
    bit m_lost;

    task automatic model_restart();
        m_idx = 0; m_cross = 0; m_in_win = 0; m_last_neg = 0;
    endtask

    task automatic model_reset();
        model_restart();
        m_dr = 0; m_lost = 0;
    endtask

    task automatic model_sample(input int v);
        int   d;
        exp_t e;
        bit   handled;
        handled = 0;
        m_idx++;
        if (v <= -HYST) begin
            m_last_neg = 1;
        end else if (v >= HYST && m_last_neg) begin
            m_last_neg = 0;
            if (!m_in_win) begin
                m_in_win = 1; m_idx = 0; m_cross = 0; handled = 1;
            end else begin
                m_cross++;
                if (m_cross == PERIODS) begin
                    d = (m_dr ? NOM_DR : NOM_DB) - m_idx;
                    if (d > 127) d = 127;
                    if (d < -128) d = -128;
                    e.dev = d; e.is_dr = int'(m_dr); e.cyc = cyc + 1;
                    exp_q.push_back(e);
                    m_idx = 0; m_cross = 0; m_lost = 0; handled = 1;
                end
            end
        end
        if (!handled && m_idx == TIMEOUT) begin
            m_lost = 1;
            model_restart();
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and held for one cycle.
    task automatic drive(input bit v, input int s, input bit ls, input bit ldr);
        in_valid   = v;
        in         = 8'(s);
        line_start = ls;
        line_is_dr = ldr;
        if (ls) begin
            m_dr = ldr;
            model_restart();
        end else if (v) begin
            model_sample(s);
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        line_start = 1'b0;
    endtask

    // Square wave starting with the negative half; amp 0 = random amplitude.
    task automatic wave(input int half, input int n, input int amp, input int gap_pct);
        int a;
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(99)) < gap_pct)
                drive(0, int'($urandom_range(255)) - 128, 0, 0);
            a = (amp != 0) ? amp : int'($urandom_range(127, HYST));
            drive(1, ((i / half) % 2 == 0) ? -a : a, 0, 0);
        end
    endtask

    task automatic check_lost(input string name);
        check(name, int'(carrier_lost), int'(m_lost));
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        in_valid   = 1'b1;
        in         = 8'sd40;
        line_start = 1'b1;
        line_is_dr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid   = 1'b0;
        line_start = 1'b0;
        line_is_dr = 1'b0;
        reset_n    = 1'b1;
        model_reset();
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_dev", int'($signed(out_dev)), 0);
        check("reset_out_is_dr", int'(out_is_dr), 0);
        check("reset_carrier_lost", int'(carrier_lost), 0);
    endtask

    // Monitor: every strobe must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_dev", int'($signed(out_dev)), e.dev);
                check("out_is_dr", int'(out_is_dr), e.is_dr);
                check("out_latency_cycle", cyc, e.cyc);
                check("lost_clear_with_valid", int'(carrier_lost), 0);
            end
        end
    end

    initial begin
        int half, len, v;
        model_reset();
        do_reset();

        // Db carrier, nominal period 10, fixed amplitude.
        drive(0, 0, 1, 0);
        wave(5, 205, 40, 0);
        check_lost("lost_after_db");

        // Dr carrier, same wave.
        drive(0, 0, 1, 1);
        wave(5, 205, 40, 0);
        // Dr with random amplitudes and invalid gaps.
        wave(5, 300, 0, 30);

        // Db with gaps: same result as gapless.
        drive(0, 0, 1, 0);
        wave(5, 250, 0, 50);

        // Long period: measured 200, saturates to -128.
        drive(0, 0, 1, 0);
        wave(25, 450, 40, 0);

        // Flat input: timeout after 255 samples from a fresh line.
        drive(0, 0, 1, 0);
        for (int i = 0; i < 300; i++) begin
            drive(1, 0, 0, 0);
            if (i == 253) check_lost("lost_before_timeout");
            if (i == 254) check_lost("lost_at_timeout");
        end
        check_lost("lost_after_flat");
        wave(5, 60, 40, 0);
        check_lost("lost_after_recovery");

        // line_start mid-window coincident with a valid sample.
        wave(5, 25, 40, 0);
        drive(1, 40, 1, 0);
        wave(5, 100, 40, 0);

        // Samples inside the hysteresis band do nothing; band edge is decisive.
        drive(0, 0, 1, 0);
        for (int i = 0; i < 100; i++)
            drive(1, int'($urandom_range(2 * HYST - 2)) - (HYST - 1), 0, 0);
        wave(5, 100, HYST - 1, 0);
        wave(5, 100, HYST, 0);
        check_lost("lost_after_hyst");

        // Random segments: varying period, noise, line type changes.
        for (int seg = 0; seg < 40; seg++) begin
            half = int'($urandom_range(28, 2));
            len  = int'($urandom_range(150, 20));
            if ($urandom_range(4) == 0) drive(0, 0, 1, 1'($urandom_range(1)));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(9) == 0)
                    v = int'($urandom_range(2 * HYST - 2)) - (HYST - 1);
                else
                    v = int'($urandom_range(127, HYST));
                if ((i / half) % 2 == 0) v = -v;
                if ($urandom_range(5) == 0) drive(0, 0, 0, 0);
                drive(1, v, 0, 0);
            end
            check_lost("lost_random_seg");
        end

        // Reset in the middle of a window discards it.
        drive(0, 0, 1, 1);
        wave(5, 30, 40, 0);
        do_reset();
        wave(5, 60, 40, 0);

        repeat (5) drive(0, 0, 0, 0);
        check("pending_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
